seq_detect_ctrl: RTL and testbench

Frame-based controller for the serial sequence-detector datapath. It holds a programmable pattern, length and overlap mode, and gates a valid/ready serial bit stream for a configured frame length. It raises a match pulse per detection, accumulates a saturating match count, and signals frame completion. It sits between the bit source and downstream status logic and replaces hard-wired overlap/non-overlap detector variants.

---
 rtl/seq_detect_ctrl.sv | 149 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Frame-based serial pattern detector: programmable pattern/length/overlap,
// valid/ready bit intake bounded by a frame length, match pulse and saturating count.
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_frame_len,
  input  logic             start,
  input  logic             abort,
  input  logic             x_valid,
  input  logic             x,
  output logic             x_ready,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [PAT_W-1:0] pat_reg, pat_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             ovl_reg, ovl_next;
  logic [CNT_W-1:0] flen_reg, flen_next;
  // Only PAT_W-1 past bits are kept; the incoming bit completes the window.
  logic [PAT_W-2:0] hist_reg, hist_next;
  logic [LEN_W-1:0] fill_reg, fill_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;
  logic             y_reg, y_next;
  logic             err_reg, err_next;

  logic [PAT_W-1:0] len_mask;
  logic [PAT_W-1:0] window;
  logic [LEN_W-1:0] fill_inc;
  logic             hit;
  logic             cfg_ok;
  logic             last_bit;

  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_reg);
    end
  endgenerate

  assign window   = {hist_reg, x};
  assign fill_inc = (fill_reg == LEN_W'(PAT_W)) ? fill_reg : fill_reg + LEN_W'(1);
  assign hit      = (fill_inc >= len_reg) && (((window ^ pat_reg) & len_mask) == '0);
  assign last_bit = ((bit_cnt_reg + CNT_W'(1)) == flen_reg);
  assign cfg_ok   = (len_reg != '0) && (len_reg <= LEN_W'(PAT_W)) && (flen_reg != '0);

  always_comb begin
    state_next     = state_reg;
    pat_next       = pat_reg;
    len_next       = len_reg;
    ovl_next       = ovl_reg;
    flen_next      = flen_reg;
    hist_next      = hist_reg;
    fill_next      = fill_reg;
    bit_cnt_next   = bit_cnt_reg;
    match_cnt_next = match_cnt_reg;
    y_next         = 1'b0;
    err_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_we) begin
          pat_next  = cfg_pattern;
          len_next  = cfg_len;
          ovl_next  = cfg_overlap;
          flen_next = cfg_frame_len;
        end
        // start judges the configuration held before this edge
        if (start) begin
          if (cfg_ok) begin
            state_next     = RUN;
            hist_next      = '0;
            fill_next      = '0;
            bit_cnt_next   = '0;
            match_cnt_next = '0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (x_valid) begin
          hist_next    = window[PAT_W-2:0];
          fill_next    = (hit && !ovl_reg) ? '0 : fill_inc;
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          if (hit) begin
            y_next = 1'b1;
            if (match_cnt_reg != '1) match_cnt_next = match_cnt_reg + CNT_W'(1);
          end
          if (last_bit) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pat_reg       <= '0;
      len_reg       <= '0;
      ovl_reg       <= 1'b0;
      flen_reg      <= '0;
      hist_reg      <= '0;
      fill_reg      <= '0;
      bit_cnt_reg   <= '0;
      match_cnt_reg <= '0;
      y_reg         <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pat_reg       <= pat_next;
      len_reg       <= len_next;
      ovl_reg       <= ovl_next;
      flen_reg      <= flen_next;
      hist_reg      <= hist_next;
      fill_reg      <= fill_next;
      bit_cnt_reg   <= bit_cnt_next;
      match_cnt_reg <= match_cnt_next;
      y_reg         <= y_next;
      err_reg       <= err_next;
    end
  end

  assign x_ready   = (state_reg == RUN);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign y         = y_reg;
  assign err       = err_reg;
  assign match_cnt = match_cnt_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed and randomized frames for seq_detect_ctrl, checked against a
// bit-list reference model of the detection rules.
module tb_seq_detect_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst, cfg_we, cfg_overlap, start, abort, x_valid, x;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_frame_len;
  logic             x_ready, y, busy, done, err;
  logic [CNT_W-1:0] match_cnt;

  int vectors = 0;
  int miscompares = 0;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_frame_len(cfg_frame_len),
    .start(start), .abort(abort), .x_valid(x_valid), .x(x),
    .x_ready(x_ready), .y(y), .match_cnt(match_cnt), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Runs one frame; abort_at >= 0 aborts once that many bits are accepted.
  task automatic run_frame(input logic [7:0] pat, input int len, input bit ovl, input int flen,
                           input bit fixed, input logic [254:0] stream, input int stall_pct,
                           input int abort_at, output int final_cnt);
    bit seen[$];
    int since = 0, n = 0, cnt = 0, cyc = 0;
    bit exp_y, m;
    cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    cfg_frame_len = CNT_W'(flen); cfg_we = 1; step;
    cfg_we = 0; start = 1; step;
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_ready", x_ready, 1);
    chk("start_cnt", match_cnt, 0);
    while (n < flen && cyc < 2000) begin
      cyc++;
      x_valid = ($urandom_range(0, 99) >= stall_pct);
      x = fixed ? stream[n] : 1'($urandom_range(0, 1));
      // Config writes and starts while running must be ignored
      cfg_we = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      cfg_pattern = 8'($urandom); cfg_len = LEN_W'($urandom_range(0, 15));
      cfg_overlap = 1'($urandom_range(0, 1));
      if (abort_at >= 0 && n == abort_at) begin
        x_valid = 1; abort = 1;
      end
      step;
      if (abort) begin
        abort = 0; x_valid = 0; cfg_we = 0; start = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_y", y, 0);
        chk("abort_cnt", match_cnt, cnt);
        step;
        chk("abort_done2", done, 0);
        chk("abort_cnt2", match_cnt, cnt);
        final_cnt = cnt;
        return;
      end
      exp_y = 0;
      if (x_valid) begin
        seen.push_back(x); n++; since++;
        m = (since >= len);
        for (int i = 0; i < len; i++)
          if (pat[i] != seen[seen.size() - 1 - i]) m = 0;
        if (m) begin
          exp_y = 1;
          if (cnt < 255) cnt++;
          if (!ovl) since = 0;
        end
      end
      chk("y", y, exp_y);
      chk("match_cnt", match_cnt, cnt);
      chk("done", done, n == flen);
      chk("x_ready", x_ready, n != flen);
      chk("busy", busy, 1);
      chk("err_run", err, 0);
    end
    x_valid = 0; cfg_we = 0; start = 0;
    chk("frame_bits", n, flen);
    step;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_cnt", match_cnt, cnt);
    final_cnt = cnt;
  endtask

  task automatic try_bad(input int len, input int flen, input int prev_cnt);
    cfg_pattern = 8'hA5; cfg_len = LEN_W'(len); cfg_overlap = 1;
    cfg_frame_len = CNT_W'(flen); cfg_we = 1; step;
    cfg_we = 0; start = 1; step;
    start = 0;
    chk("bad_err", err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_cnt", match_cnt, prev_cnt);
    step;
    chk("bad_err_off", err, 0);
    chk("bad_busy2", busy, 0);
  endtask

  initial begin
    int fc, last_cnt;
    logic [254:0] s;
    rst = 1; cfg_we = 0; cfg_overlap = 0; start = 0; abort = 0; x_valid = 0; x = 0;
    cfg_pattern = 0; cfg_len = 0; cfg_frame_len = 0;
    step; step;
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_ready", x_ready, 0);
    chk("rst_y", y, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", match_cnt, 0);

    s = '0; s[6:0] = 7'b1101101;  // stream 1,0,1,1,0,1,1 (bit 0 first)
    run_frame(8'b1011, 4, 1, 7, 1, s, 0, -1, fc);
    chk("overlap_total", fc, 2);
    run_frame(8'b1011, 4, 0, 7, 1, s, 0, -1, fc);
    chk("nonoverlap_total", fc, 1);
    run_frame(8'b1011, 4, 1, 7, 1, s, 40, -1, fc);
    chk("stall_total", fc, 2);
    last_cnt = fc;

    try_bad(0, 7, last_cnt);
    try_bad(9, 7, last_cnt);
    try_bad(4, 0, last_cnt);

    run_frame(8'b1011, 4, 1, 7, 1, s, 0, 3, fc);
    chk("abort_total", fc, 0);

    s = '1;
    run_frame(8'b1, 1, 1, 255, 1, s, 0, -1, fc);
    chk("allones_total", fc, 255);

    for (int f = 0; f < 8; f++) begin
      run_frame(8'($urandom), $urandom_range(1, 8), 1'($urandom_range(0, 1)),
                $urandom_range(1, 40), 0, s, 30, -1, fc);
    end

    // start coincident with a config write uses the previous config
    cfg_pattern = 8'b1; cfg_len = 1; cfg_overlap = 1; cfg_frame_len = 20; cfg_we = 1; step;
    cfg_len = 0; start = 1; step;
    cfg_we = 0; start = 0;
    chk("samecyc_busy", busy, 1);
    chk("samecyc_err", err, 0);
    abort = 1; step;
    abort = 0;
    chk("samecyc_abort", busy, 0);
    start = 1; step;
    start = 0;
    chk("samecyc_newcfg_err", err, 1);

    // reset in the middle of a frame
    cfg_len = 1; cfg_frame_len = 20; cfg_we = 1; step;
    cfg_we = 0; start = 1; step;
    start = 0; x = 1; x_valid = 1; step; step; step;
    chk("pre_rst_cnt", match_cnt, 3);
    rst = 1; step;
    rst = 0; x_valid = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", x_ready, 0);
    chk("midrst_y", y, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_cnt", match_cnt, 0);
    start = 1; step;
    start = 0;
    chk("midrst_cfg_cleared", err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
